apb_multi_slave: RTL
====================

APB_MULTI_SLAVE -- requirements
Module: apb_multi_slave

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4: number of PSEL lines and independent slave memories.
REQ-002 SHALL have parameter DATA_W, default 32: PWDATA/PRDATA width, a multiple of 8.
REQ-003 SHALL have parameter ADDR_W, default 32: PADDR width.
REQ-004 SHALL have parameter MEM_DEPTH, default 16: words per slave, a power of 2.
REQ-005 SHALL have parameter WAIT_W, default 3: width of each per-slave wait-state field.
REQ-006 SHALL have port CLK  input  1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port PRESETn  input  1: reset, synchronous and active-low.
REQ-008 SHALL have port PSEL  input  NUM_SLV: one-hot slave select.
REQ-009 SHALL have port PENABLE  input  1: access phase.
REQ-010 SHALL have port PWRITE  input  1: 1 = write, 0 = read.
REQ-011 SHALL have port PADDR  input  ADDR_W: byte address.
REQ-012 SHALL have port PWDATA  input  DATA_W: write data.
REQ-013 SHALL have port PSTRB  input  DATA_W/8: byte-lane write strobes.
REQ-014 SHALL have port WAIT_CFG  input  NUM_SLV*WAIT_W: wait states per slave; slave i uses field i.
REQ-015 SHALL have port PRDATA  output  DATA_W: read data.
REQ-016 SHALL have port PREADY  output  1: transfer complete.
REQ-017 SHALL have port PSLVERR  output  1: transfer error, valid only while PREADY=1.

Function
REQ-018 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-019 IDLE->SETUP SHALL occur when |PSEL=1 and PENABLE=0. In SETUP the block SHALL latch the slave index, PADDR, PWRITE, PWDATA and PSTRB, and SHALL load wcnt from WAIT_CFG[idx].
REQ-020 SETUP->ACCESS SHALL always occur on the next edge.
REQ-021 In ACCESS, PREADY SHALL be 1 exactly when wcnt==0. While wcnt!=0, wcnt SHALL decrement by 1 per cycle. Latency from the first ACCESS cycle to PREADY is WAIT_CFG[idx] cycles; a value of 0 gives a zero-wait transfer.
REQ-022 On the edge where PREADY=1 the FSM SHALL leave ACCESS:
  - to SETUP if |PSEL=1 and PENABLE=0 (back-to-back transfer);
  - otherwise to IDLE.
REQ-023 A write SHALL commit on the PREADY edge to mem[idx][word] for byte lanes with PSTRB=1 only.
REQ-024 The word index SHALL be PADDR[log2(MEM_DEPTH)+1:2].
REQ-025 A read SHALL drive PRDATA = mem[idx][word] while PREADY=1, and 0 at all other times.
REQ-026 PSLVERR=1 with PREADY SHALL be raised, with no write performed and PRDATA=0, in each of these cases:
  - PSEL is not one-hot;
  - PADDR[1:0]!=0;
  - any PADDR bit above log2(MEM_DEPTH)+1 is nonzero.
REQ-027 In ACCESS, if PSEL changes from its latched value or PENABLE=0 before PREADY, the block SHALL abort to IDLE with no write, PREADY=0 and PSLVERR=0.
REQ-028 A read and a write to the same word in consecutive transfers SHALL return the newly written data (no stale read).
REQ-029 A change to WAIT_CFG during ACCESS SHALL not affect the transfer in progress.

Reset
REQ-030 When PRESETn=0 at a rising CLK, the block SHALL set:
  - state to IDLE, wcnt to 0;
  - PREADY, PSLVERR and PRDATA to 0;
  - all memory words of all slaves to 0.
REQ-031 A reset asserted mid-transfer SHALL abandon that transfer with no memory update, and it SHALL take precedence over every other event on that edge.
REQ-032 The block SHALL accept a SETUP on the first edge after PRESETn returns to 1.

Structure
REQ-033 The state enum (IDLE/SETUP/ACCESS) and the default parameter constants SHALL reside in shared package apb_pkg.
REQ-034 The per-slave storage SHALL be sub-module apb_slv_mem (MEM_DEPTH x DATA_W, byte-strobe write, synchronous reset clear), instantiated NUM_SLV times by generate.
REQ-035 The FSM, wait counter and error decode SHALL be in apb_multi_slave.

Verification
REQ-036 Zero-wait write/read: WAIT_CFG=0, write 0xDEADBEEF to slave 1 at 0x08, then read it back -> PREADY in the first ACCESS cycle both times; PRDATA=0xDEADBEEF; PSLVERR=0.
REQ-037 Wait states: WAIT_CFG[slave 2]=5, read slave 2 -> PREADY exactly 5 cycles after the first ACCESS cycle.
REQ-038 Strobes: mem=0x11223344, write 0xAABBCCDD with PSTRB=0101 -> a subsequent read returns 0x11BB33DD.
REQ-039 Errors:
  - PSEL=0011 -> PSLVERR=1 with PREADY;
  - PADDR=0x06 -> PSLVERR=1 with PREADY;
  - PADDR=0x40 with MEM_DEPTH=16 -> PSLVERR=1 with PREADY;
  - in all three cases memory is unchanged.
REQ-040 Abort and reset: drop PENABLE during a 3-wait write -> no write and state returns to IDLE; separately, assert PRESETn=0 mid-ACCESS -> outputs are 0 next cycle and a read of any address returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB multi-slave block: the transfer FSM state
// encoding and the default parameter values used by the top and the slave memories.
package apb_pkg;

   localparam int NUM_SLV_DEF   = 4;
   localparam int DATA_W_DEF    = 32;
   localparam int ADDR_W_DEF    = 32;
   localparam int MEM_DEPTH_DEF = 16;
   localparam int WAIT_W_DEF    = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_slv_mem.sv
// One slave's word storage: register array with byte-strobe writes, a
// combinational read port and a synchronous clear on reset.
module apb_slv_mem
   import apb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         we,
   input  logic [$clog2(MEM_DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          strb,
   output logic [DATA_W-1:0]            rdata
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // Reset wipes every word so reads after reset return zero.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (strb[b]) begin
               mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/apb_multi_slave.sv
// APB front end serving NUM_SLV independent slave memories: transfer FSM,
// per-slave programmable wait states, error decode and abort handling.
module apb_multi_slave
   import apb_pkg::*;
#(
   parameter int NUM_SLV   = NUM_SLV_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF,
   parameter int WAIT_W    = WAIT_W_DEF
) (
   input  logic                      CLK,
   input  logic                      PRESETn,
   input  logic [NUM_SLV-1:0]        PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [ADDR_W-1:0]         PADDR,
   input  logic [DATA_W-1:0]         PWDATA,
   input  logic [DATA_W/8-1:0]       PSTRB,
   input  logic [NUM_SLV*WAIT_W-1:0] WAIT_CFG,
   output logic [DATA_W-1:0]         PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR
);

   localparam int AW     = $clog2(MEM_DEPTH);
   localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int STRB_W = DATA_W/8;

   apb_state_e state, state_nxt;

   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   idx_q;
   logic [NUM_SLV-1:0] psel_q;
   logic [AW-1:0]      word_q;
   logic               write_q;
   logic               err_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [STRB_W-1:0]  strb_q;
   logic [WAIT_W-1:0]  wcnt;

   logic setup_req;
   logic addr_err;
   logic ready;
   logic abort;

   logic [DATA_W-1:0] slv_rdata [NUM_SLV];

   assign setup_req = (|PSEL) && !PENABLE;
   assign addr_err  = (PADDR[1:0] != 2'b00) || ((PADDR >> (AW + 2)) != '0);
   assign ready     = (state == ACCESS) && (wcnt == '0);
   assign abort     = (state == ACCESS) && (wcnt != '0) && ((PSEL != psel_q) || !PENABLE);

   // Lowest set PSEL bit; only meaningful when PSEL is one-hot, otherwise the
   // transfer is flagged as an error and never touches memory.
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (PSEL[i]) begin
            sel_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (setup_req) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS: begin
            if (ready) begin
               state_nxt = setup_req ? SETUP : IDLE;
            end else if (abort) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transfer context is captured on entry to SETUP so later WAIT_CFG or bus
   // changes cannot disturb a transfer already in flight.
   always_ff @(posedge CLK) begin
      if (!PRESETn) begin
         state   <= IDLE;
         wcnt    <= '0;
         idx_q   <= '0;
         psel_q  <= '0;
         word_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt == SETUP) begin
            idx_q   <= sel_idx;
            psel_q  <= PSEL;
            word_q  <= PADDR[AW+1:2];
            write_q <= PWRITE;
            err_q   <= !$onehot(PSEL) || addr_err;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            wcnt    <= WAIT_CFG[sel_idx*WAIT_W +: WAIT_W];
         end else if ((state == ACCESS) && (wcnt != '0)) begin
            wcnt <= wcnt - WAIT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
      apb_slv_mem #(
         .DATA_W    (DATA_W),
         .MEM_DEPTH (MEM_DEPTH)
      ) u_mem (
         .clk    (CLK),
         .resetn (PRESETn),
         .we     (ready && write_q && !err_q && (idx_q == IDX_W'(g))),
         .addr   (word_q),
         .wdata  (wdata_q),
         .strb   (strb_q),
         .rdata  (slv_rdata[g])
      );
   end

   assign PREADY  = ready;
   assign PSLVERR = ready && err_q;
   assign PRDATA  = (ready && !write_q && !err_q) ? slv_rdata[idx_q] : '0;

endmodule
